// File: rtl/dac_playback_sequencer_pkg.sv
// Shared types and default sizes for the DAC playback sequencer.
package dac_seq_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DW_DEF      = 10;
  localparam int BURST_W_DEF = 4;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_e;

  function automatic logic state_is_busy(input seq_state_e st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/dac_playback_sequencer_if.sv
// Wave memory read port and DAC FIFO write/status port as seen by the sequencer.
import dac_seq_pkg::*;

interface dac_playback_sequencer_if #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW     = DW_DEF
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              dac_wr;
  logic [DW-1:0]     dac_data;
  logic              dac_low;
  logic              dac_empty;

  modport master (
    output mem_rd, mem_addr, dac_wr, dac_data,
    input  mem_rdata, dac_low, dac_empty
  );

  modport slave (
    input  mem_rd, mem_addr, dac_wr, dac_data,
    output mem_rdata, dac_low, dac_empty
  );
endinterface

// File: rtl/dac_playback_sequencer_addr_gen.sv
// Window address generator: current address plus samples remaining in the window.
import dac_seq_pkg::*;

module dac_seq_addr_gen #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              reload,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] length_in,
  output logic [ADDR_W-1:0] addr,
  output logic              window_end
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remaining_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] length_reg;

  // base/length are kept so a looping window can restart without the inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      base_reg      <= '0;
      length_reg    <= '0;
    end else if (load) begin
      addr_reg      <= base_in;
      remaining_reg <= length_in;
      base_reg      <= base_in;
      length_reg    <= length_in;
    end else if (reload) begin
      addr_reg      <= base_reg;
      remaining_reg <= length_reg;
    end else if (step) begin
      addr_reg <= addr_reg + 1'b1;
      if (remaining_reg != '0)
        remaining_reg <= remaining_reg - 1'b1;
    end
  end

  assign addr       = addr_reg;
  assign window_end = (remaining_reg == '0);

endmodule

// File: rtl/dac_playback_sequencer.sv
// Refills the DAC sample FIFO from wave memory in bursts triggered by FIFO low.
// Optional DAC_SEQ_LOOP_COUNT_EN adds a bounded repeat count for looped playback.
import dac_seq_pkg::*;

module dac_playback_sequencer #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DW      = DW_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  length,
  input  logic [BURST_W-1:0] burst_len,
`ifdef DAC_SEQ_LOOP_COUNT_EN
  input  logic [7:0]         loop_count,
`endif
  dac_playback_sequencer_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  seq_state_e         state_reg, state_next;
  logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [BURST_W-1:0] burst_len_reg, burst_len_next;
  logic               loop_en_reg, loop_en_next;
  logic               first_done_reg, first_done_next;
  logic               underrun_reg, underrun_next;
  logic               done_pend_reg, done_pend_next;
  logic               dac_wr_reg;
  logic               ag_load, ag_step, ag_reload;
  logic [ADDR_W-1:0]  ag_addr;
  logic               ag_window_end;
  logic               loop_more;
  logic [DW-1:0]      rdata;

`ifdef DAC_SEQ_LOOP_COUNT_EN
  logic [7:0] loop_cnt_reg, loop_cnt_next;
  assign loop_more = loop_en_reg && (loop_cnt_reg != 8'd0);
`else
  assign loop_more = loop_en_reg;
`endif

  dac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ag_load),
    .step       (ag_step),
    .reload     (ag_reload),
    .base_in    (base_addr),
    .length_in  (length),
    .addr       (ag_addr),
    .window_end (ag_window_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      burst_cnt_reg  <= '0;
      burst_len_reg  <= '0;
      loop_en_reg    <= 1'b0;
      first_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      done_pend_reg  <= 1'b0;
      dac_wr_reg     <= 1'b0;
`ifdef DAC_SEQ_LOOP_COUNT_EN
      loop_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      burst_cnt_reg  <= burst_cnt_next;
      burst_len_reg  <= burst_len_next;
      loop_en_reg    <= loop_en_next;
      first_done_reg <= first_done_next;
      underrun_reg   <= underrun_next;
      done_pend_reg  <= done_pend_next;
      dac_wr_reg     <= bus.mem_rd;
`ifdef DAC_SEQ_LOOP_COUNT_EN
      loop_cnt_reg   <= loop_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    burst_cnt_next  = burst_cnt_reg;
    burst_len_next  = burst_len_reg;
    loop_en_next    = loop_en_reg;
    first_done_next = first_done_reg;
    underrun_next   = underrun_reg;
    done_pend_next  = done_pend_reg;
    ag_load         = 1'b0;
    ag_step         = 1'b0;
    ag_reload       = 1'b0;
`ifdef DAC_SEQ_LOOP_COUNT_EN
    loop_cnt_next   = loop_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next      = ST_WAIT;
          ag_load         = 1'b1;
          burst_len_next  = burst_len;
          loop_en_next    = loop_en;
          first_done_next = 1'b0;
          underrun_next   = 1'b0;
          done_pend_next  = 1'b0;
`ifdef DAC_SEQ_LOOP_COUNT_EN
          loop_cnt_next   = loop_count;
`endif
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_next = ST_FLUSH;
        end else if (bus.dac_low) begin
          burst_cnt_next = burst_len_reg;
          state_next     = ST_BURST;
        end else if (first_done_reg && bus.dac_empty) begin
          underrun_next = 1'b1;
        end
      end
      ST_BURST: begin
        if (stop) begin
          state_next = ST_FLUSH;
        end else if (ag_window_end && loop_more) begin
          ag_reload = 1'b1;
`ifdef DAC_SEQ_LOOP_COUNT_EN
          loop_cnt_next = loop_cnt_reg - 8'd1;
`endif
          if (burst_cnt_reg == '0) begin
            first_done_next = 1'b1;
            state_next      = ST_WAIT;
          end else begin
            burst_cnt_next = burst_cnt_reg - 1'b1;
          end
        end else if (ag_window_end) begin
          // last read of a finite playback; its write lands during FLUSH
          ag_step        = 1'b1;
          done_pend_next = 1'b1;
          state_next     = ST_FLUSH;
        end else begin
          ag_step = 1'b1;
          if (burst_cnt_reg == '0) begin
            first_done_next = 1'b1;
            state_next      = ST_WAIT;
          end else begin
            burst_cnt_next = burst_cnt_reg - 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        done_pend_next = 1'b0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd   = (state_reg == ST_BURST) && !stop;
    bus.mem_addr = ag_addr;
    bus.dac_wr   = dac_wr_reg;
    busy         = state_is_busy(state_reg);
    done         = (state_reg == ST_FLUSH) && done_pend_reg;
    underrun     = underrun_reg;
  end

  assign rdata        = bus.mem_rdata;
  assign bus.dac_data = rdata;

endmodule

// File: tb/tb_dac_playback_sequencer.sv
// Directed bench for dac_playback_sequencer with a synchronous wave-memory model.
`timescale 1ns/1ps
import dac_seq_pkg::*;

module tb_dac_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop_en;
  logic [9:0] base_addr, length;
  logic [3:0] burst_len;
  logic       busy, done, underrun;
`ifdef DAC_SEQ_LOOP_COUNT_EN
  logic [7:0] loop_count;
`endif

  int checks = 0;
  int errors = 0;

  dac_playback_sequencer_if #(.ADDR_W(10), .DW(10)) bus ();

  dac_playback_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .base_addr (base_addr),
    .length    (length),
    .burst_len (burst_len),
`ifdef DAC_SEQ_LOOP_COUNT_EN
    .loop_count(loop_count),
`endif
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mem_val(input logic [9:0] a);
    return a ^ 10'h2A5;
  endfunction

  // wave memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_val(bus.mem_addr);
  end

  logic [9:0] wr_q[$];
  logic [9:0] rd_q[$];
  int  done_cnt = 0;
  int  lat_err  = 0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (bus.dac_wr) begin
      wr_q.push_back(bus.dac_data);
      if (!prev_rd) lat_err++;
      $display("t=%0t dac_wr data=%03h", $time, bus.dac_data);
    end
    if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
    if (done) done_cnt++;
    prev_rd = bus.mem_rd;
  end

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic config_shot();
    base_addr = 10'h010;
    length    = 10'd7;
    burst_len = 4'd3;
    loop_en   = 1'b0;
  endtask

  int wb, rb, db, n0;
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    base_addr = '0; length = '0; burst_len = '0;
    bus.dac_low = 1'b0; bus.dac_empty = 1'b0; bus.mem_rdata = '0;
`ifdef DAC_SEQ_LOOP_COUNT_EN
    loop_count = 8'd0;
`endif
    ticks(3);
    `CHK("reset_busy", busy, 1'b0)
    `CHK("reset_done", done, 1'b0)
    `CHK("reset_underrun", underrun, 1'b0)
    `CHK("reset_mem_rd", bus.mem_rd, 1'b0)
    `CHK("reset_dac_wr", bus.dac_wr, 1'b0)
    `CHK("reset_mem_addr", bus.mem_addr, 10'h000)
    rst = 1'b0;
    tick();

    // single shot, FIFO always low
    config_shot();
    bus.dac_low = 1'b1;
    wb = wr_q.size(); rb = rd_q.size(); db = done_cnt;
    pulse_start();
    `CHK("t1_busy_after_start", busy, 1'b1)
    wait_done(found);
    `CHK("t1_done_seen", found, 1'b1)
    `CHK("t1_busy_at_done", busy, 1'b1)
    tick();
    `CHK("t1_busy_after_done", busy, 1'b0)
    `CHK("t1_done_one_cycle", done, 1'b0)
    tick();
    `CHK("t1_wr_count", wr_q.size() - wb, 8)
    `CHK("t1_done_count", done_cnt - db, 1)
    `CHK("t1_latency", lat_err, 0)
    for (int i = 0; i < 8; i++) begin
      if (wb + i < wr_q.size())
        `CHK("t1_data", wr_q[wb+i], mem_val(10'h010 + 10'(i)))
      if (rb + i < rd_q.size())
        `CHK("t1_addr", rd_q[rb+i], 10'h010 + 10'(i))
    end

    // low gating: FIFO stops asking after the first burst starts
    wb = wr_q.size(); db = done_cnt;
    bus.dac_low = 1'b1;
    pulse_start();
    tick();
    bus.dac_low = 1'b0;
    ticks(10);
    `CHK("t2_first_burst_writes", wr_q.size() - wb, 4)
    `CHK("t2_stalled_busy", busy, 1'b1)
    bus.dac_low = 1'b1;
    wait_done(found);
    `CHK("t2_done_seen", found, 1'b1)
    ticks(2);
    `CHK("t2_total_writes", wr_q.size() - wb, 8)
    `CHK("t2_last_data", wr_q[wr_q.size()-1], mem_val(10'h017))
    `CHK("t2_no_underrun", underrun, 1'b0)

    // wrap and loop, then stop
    base_addr = 10'h3FE; length = 10'd2; burst_len = 4'd3; loop_en = 1'b1;
    rb = rd_q.size(); db = done_cnt;
    pulse_start();
    ticks(12);
    `CHK("t3_enough_reads", (rd_q.size() - rb) >= 6, 1'b1)
    `CHK("t3_addr0", rd_q[rb+0], 10'h3FE)
    `CHK("t3_addr1", rd_q[rb+1], 10'h3FF)
    `CHK("t3_addr2", rd_q[rb+2], 10'h000)
    `CHK("t3_addr3", rd_q[rb+3], 10'h3FE)
    `CHK("t3_addr4", rd_q[rb+4], 10'h3FF)
    `CHK("t3_addr5", rd_q[rb+5], 10'h000)
    n0 = wr_q.size();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    `CHK("t3_idle_after_stop", busy, 1'b0)
    ticks(2);
    `CHK("t3_tail_writes", (wr_q.size() - n0) <= 1, 1'b1)
    `CHK("t3_no_done", done_cnt - db, 0)

    // underrun after first burst, sticky until next start
    base_addr = 10'h100; length = 10'd15; burst_len = 4'd1; loop_en = 1'b0;
    bus.dac_low = 1'b1;
    pulse_start();
    tick();
    bus.dac_low = 1'b0;
    bus.dac_empty = 1'b1;
    ticks(5);
    `CHK("t4_underrun_set", underrun, 1'b1)
    bus.dac_empty = 1'b0;
    ticks(3);
    `CHK("t4_underrun_sticky", underrun, 1'b1)
    stop = 1'b1; tick(); stop = 1'b0; ticks(2);
    `CHK("t4_sticky_after_stop", underrun, 1'b1)
    pulse_start();
    `CHK("t4_cleared_by_start", underrun, 1'b0)
    stop = 1'b1; tick(); stop = 1'b0; ticks(2);
    `CHK("t4_idle", busy, 1'b0)

    // start and stop together: stop wins
    config_shot();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    `CHK("t5_start_stop_idle", busy, 1'b0)

    // start while busy is ignored
    bus.dac_low = 1'b1;
    wb = wr_q.size(); rb = rd_q.size();
    pulse_start();
    ticks(3);
    base_addr = 10'h200; length = 10'd0;
    pulse_start();
    wait_done(found);
    `CHK("t5_done_seen", found, 1'b1)
    ticks(2);
    `CHK("t5_reads", rd_q.size() - rb, 8)
    `CHK("t5_first_addr", rd_q[rb], 10'h010)
    `CHK("t5_last_addr", rd_q[rb+7], 10'h017)

    // reset in the middle of a burst
    config_shot();
    pulse_start();
    tick();
    tick();
    `CHK("t6_reading", bus.mem_rd, 1'b1)
    rst = 1'b1;
    tick();
    `CHK("t6_no_dac_wr", bus.dac_wr, 1'b0)
    `CHK("t6_mem_rd", bus.mem_rd, 1'b0)
    `CHK("t6_busy", busy, 1'b0)
    `CHK("t6_mem_addr", bus.mem_addr, 10'h000)
    `CHK("t6_done", done, 1'b0)
    `CHK("t6_underrun", underrun, 1'b0)
    rst = 1'b0;
    tick();

`ifdef DAC_SEQ_LOOP_COUNT_EN
    // bounded loop: window played loop_count+1 times
    base_addr = 10'h020; length = 10'd3; burst_len = 4'd3; loop_en = 1'b1;
    loop_count = 8'd2;
    wb = wr_q.size(); db = done_cnt;
    pulse_start();
    wait_done(found);
    `CHK("t7_done_seen", found, 1'b1)
    ticks(2);
    `CHK("t7_writes", wr_q.size() - wb, 12)
    `CHK("t7_done_count", done_cnt - db, 1)
    `CHK("t7_last_data", wr_q[wr_q.size()-1], mem_val(10'h023))
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
